// File: rtl/sram_stream_reader.sv
// Streams word_count consecutive 16-bit words from an sram read port out over valid/ready.
// Reads are throttled so every returning word has a slot, and are held off after same-word writes.
module sram_stream_reader #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset_b,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_address,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] read_address,
    output logic                  read_enable,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic [ADDR_WIDTH-1:0] snoop_write_address,
    input  logic                  snoop_write_enable,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] next_address;
    logic [CNT_WIDTH-1:0]  issue_left;
    logic [CNT_WIDTH-1:0]  capture_left;
    logic [CNT_WIDTH-1:0]  deliver_left;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_valid;
    logic                  skid_last;

    logic       capture;
    logic       pop;
    logic       hazard;
    logic       issue;
    logic       capture_last;
    logic [1:0] occupancy_next;

    always_comb begin
        // The read presented this cycle returns at the coming edge, so it is captured now.
        capture        = read_enable;
        pop            = out_valid && out_ready;
        capture_last   = (capture_left == CNT_WIDTH'(1));
        occupancy_next = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, capture} - {1'b0, pop};
        // A write seen at this edge lands in memory now; a same-word read next cycle would be X.
        hazard         = snoop_write_enable &&
                         ((snoop_write_address >> 1) == (next_address >> 1));
        issue          = (state == StRun) && (issue_left != '0) &&
                         (occupancy_next < 2'd2) && !hazard;
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state        <= StIdle;
            busy         <= 1'b0;
            done         <= 1'b0;
            read_enable  <= 1'b0;
            read_address <= '0;
            next_address <= '0;
            issue_left   <= '0;
            capture_left <= '0;
            deliver_left <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            skid_valid   <= 1'b0;
            skid_data    <= '0;
            skid_last    <= 1'b0;
        end else begin
            if (!out_valid || pop) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    out_last   <= skid_last;
                    skid_valid <= capture;
                    if (capture) begin
                        skid_data <= read_data;
                        skid_last <= capture_last;
                    end
                end else if (capture) begin
                    out_valid <= 1'b1;
                    out_data  <= read_data;
                    out_last  <= capture_last;
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end else if (capture) begin
                skid_valid <= 1'b1;
                skid_data  <= read_data;
                skid_last  <= capture_last;
            end

            if (capture) begin
                capture_left <= capture_left - CNT_WIDTH'(1);
            end
            if (pop) begin
                deliver_left <= deliver_left - CNT_WIDTH'(1);
            end

            read_enable <= issue;
            if (issue) begin
                read_address <= next_address;
                next_address <= next_address + ADDR_WIDTH'(2);
                issue_left   <= issue_left - CNT_WIDTH'(1);
            end

            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        next_address <= base_address;
                        issue_left   <= word_count;
                        capture_left <= word_count;
                        deliver_left <= word_count;
                        if (word_count == '0) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state <= StRun;
                            busy  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (issue && (issue_left == CNT_WIDTH'(1))) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (pop && (deliver_left == CNT_WIDTH'(1))) begin
                        state <= StDone;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader: a small sram model answers reads (X after same-word
// writes) and a vector table drives requests, checking addresses, data order, last, done timing.
module tb_sram_stream_reader;

    logic        clock;
    logic        reset_b;
    logic        start;
    logic [31:0] base_address;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic [31:0] read_address;
    logic        read_enable;
    logic [15:0] read_data;
    logic [31:0] snoop_write_address;
    logic        snoop_write_enable;
    logic [15:0] write_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;

    int tests = 0;
    int fails = 0;

    sram_stream_reader dut (
        .clock               (clock),
        .reset_b             (reset_b),
        .start               (start),
        .base_address        (base_address),
        .word_count          (word_count),
        .busy                (busy),
        .done                (done),
        .read_address        (read_address),
        .read_enable         (read_enable),
        .read_data           (read_data),
        .snoop_write_address (snoop_write_address),
        .snoop_write_enable  (snoop_write_enable),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_last            (out_last)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // sram model: 256 words indexed by the low word-address bits; read data is combinational on
    // the registered read port and X when the same word was written in the previous cycle.
    logic [15:0] mem [256];
    logic        last_we;
    logic [30:0] last_wword;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h3C00 + 16'(i * 5);
        last_we    = 1'b0;
        last_wword = '0;
    end

    always @(posedge clock) begin
        if (snoop_write_enable) mem[snoop_write_address[8:1]] <= write_data;
        last_we    <= snoop_write_enable;
        last_wword <= snoop_write_address[31:1];
    end

    assign read_data = !read_enable ? 16'hxxxx :
                       (last_we && (last_wword == read_address[31:1])) ? 16'hxxxx :
                       mem[read_address[8:1]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_read_enable"}, 32'(read_enable), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_last"}, 32'(out_last), 0);
        check({tag, "_read_address"}, read_address, 0);
        check({tag, "_out_data"}, 32'(out_data), 0);
    endtask

    typedef struct {
        logic [31:0] base;
        logic [15:0] count;
        logic [15:0] ready_pat;
        bit          hz;
        logic [31:0] hz_addr;
        logic [15:0] hz_data;
        int          hz_cycle;
        int          exp_last_read;  // cycle of final read after start edge, -1 = unchecked
        int          exp_done;       // cycle of done pulse after start edge, -1 = unchecked
    } vec_t;

    task automatic run_req(input vec_t v);
        int          c;
        int          nrd;
        int          nxf;
        int          caps;
        int          xfers;
        int          done_c;
        int          last_rd_c;
        logic        stalled;
        logic [15:0] sdata;
        logic        slast;
        logic [31:0] w;
        c = 0; nrd = 0; nxf = 0; caps = 0; xfers = 0; done_c = -1; last_rd_c = -1;
        stalled = 1'b0; sdata = '0; slast = 1'b0;
        @(posedge clock);
        #1;
        start        = 1'b1;
        base_address = v.base;
        word_count   = v.count;
        while (c < 200 && done_c < 0) begin
            @(posedge clock);
            #1;
            start               = 1'b0;
            out_ready           = v.ready_pat[c % 16];
            snoop_write_enable  = v.hz && (c == v.hz_cycle);
            snoop_write_address = v.hz_addr;
            write_data          = v.hz_data;
            @(negedge clock);
            if (c == 0) check("busy_after_start", 32'(busy), 32'(v.count != 0));
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_data", 32'(out_data), 32'(sdata));
                check("stall_last", 32'(out_last), 32'(slast));
            end
            if (read_enable) begin
                check("read_address", read_address, v.base + 32'(2 * nrd));
                check("issue_occupancy", 32'((caps - xfers) <= 1), 1);
                nrd++;
                last_rd_c = c;
            end
            if (out_valid && out_ready) begin
                w = (v.base >> 1) + 32'(nxf);
                check("out_data", 32'(out_data), 32'(mem[w[7:0]]));
                check("out_last", 32'(out_last), 32'(nxf == int'(v.count) - 1));
                nxf++;
            end
            stalled = out_valid && !out_ready;
            sdata   = out_data;
            slast   = out_last;
            if (read_enable) caps++;
            if (out_valid && out_ready) xfers++;
            if (done) begin
                done_c = c;
                check("busy_with_done", 32'(busy), 0);
                check("valid_with_done", 32'(out_valid), 0);
            end
            c++;
        end
        snoop_write_enable = 1'b0;
        check("done_seen", 32'(done_c >= 0), 1);
        check("reads_issued", 32'(nrd), 32'(v.count));
        check("words_out", 32'(nxf), 32'(v.count));
        if (v.exp_done >= 0) check("done_cycle", 32'(done_c), 32'(v.exp_done));
        if (v.exp_last_read >= 0) check("last_read_cycle", 32'(last_rd_c), 32'(v.exp_last_read));
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(negedge clock);
        check("done_one_cycle", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{32'h0000_0100, 16'd4, 16'hFFFF, 1'b0, 32'h0, 16'h0, 0, 4, 6};
        vecs[1] = '{32'h0000_0100, 16'd8, 16'h9999, 1'b0, 32'h0, 16'h0, 0, -1, -1};
        vecs[2] = '{32'h0000_0100, 16'd4, 16'hFFFF, 1'b1, 32'h0000_0104, 16'hBEEF, 2, 5, 7};
        vecs[3] = '{32'h0000_0100, 16'd0, 16'hFFFF, 1'b0, 32'h0, 16'h0, 0, -1, 0};
        vecs[4] = '{32'hFFFF_FFFC, 16'd3, 16'hFFFF, 1'b0, 32'h0, 16'h0, 0, 3, 5};
        vecs[5] = '{32'h0000_010A, 16'd1, 16'hFFFF, 1'b0, 32'h0, 16'h0, 0, 1, 3};
        vecs[6] = '{32'h0000_0120, 16'd5, 16'hFFF0, 1'b0, 32'h0, 16'h0, 0, 7, 9};

        reset_b             = 1'b0;
        start               = 1'b0;
        base_address        = '0;
        word_count          = '0;
        out_ready           = 1'b1;
        snoop_write_enable  = 1'b0;
        snoop_write_address = '0;
        write_data          = '0;
        #12;
        check_quiet("reset");
        @(negedge clock);
        reset_b = 1'b1;

        for (int i = 0; i < 7; i++) run_req(vecs[i]);

        // Second start while busy is ignored, then reset abandons the request.
        @(posedge clock);
        #1;
        start        = 1'b1;
        base_address = 32'h0000_0200;
        word_count   = 16'd8;
        out_ready    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            start        = (k == 2);
            base_address = 32'h0000_0300;
            word_count   = 16'd1;
            @(negedge clock);
            check("busy_run", 32'(busy), 1);
            if (k >= 1) begin
                check("run_read_enable", 32'(read_enable), 1);
                check("run_read_address", read_address, 32'h0000_0200 + 32'(2 * (k - 1)));
            end
        end
        start = 1'b0;
        #2;
        reset_b = 1'b0;
        #1;
        check_quiet("midreset");
        @(negedge clock);
        reset_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("post_reset_done", 32'(done), 0);
            check("post_reset_busy", 32'(busy), 0);
            check("post_reset_read", 32'(read_enable), 0);
        end
        run_req(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
